// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format enum, opcode constants
// and the decode-result layout.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP32     = 7'b0111011;

    // Decode result layout; users declare the same shape with imm at XLEN bits.
    typedef struct packed {
        logic [31:0] imm;
        imm_type_e   typ;
        logic        illegal;
    } imm_dec32_t;

    typedef struct packed {
        logic [63:0] imm;
        imm_type_e   typ;
        logic        illegal;
    } imm_dec64_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode: builds the XLEN-wide immediate,
// its format and an illegal flag from one instruction word.
module imm_decode
    import imm_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter type dec_t = imm_dec32_t
) (
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_xl64;

    assign w_op   = i_inst[6:0];
    assign w_f3   = i_inst[14:12];
    assign w_xl64 = (XLEN == 64);

    always_comb begin
        o_dec         = '0;
        o_dec.typ     = IMM_NONE;
        o_dec.illegal = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            o_dec.illegal = 1'b1;
        end else begin
            case (w_op)
                OP_IMM: begin
                    o_dec.typ     = IMM_I;
                    o_dec.imm     = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
                    // shamt[5] only exists on RV64
                    o_dec.illegal = !w_xl64 && is_shift(w_f3) && i_inst[25];
                end
                LOAD, JALR: begin
                    o_dec.typ = IMM_I;
                    o_dec.imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
                end
                OP_IMM32: begin
                    if (w_xl64) begin
                        o_dec.typ     = IMM_I;
                        o_dec.imm     = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
                        o_dec.illegal = is_shift(w_f3) && i_inst[25];
                    end else begin
                        o_dec.illegal = 1'b1;
                    end
                end
                STORE: begin
                    o_dec.typ = IMM_S;
                    o_dec.imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                end
                BRANCH: begin
                    o_dec.typ = IMM_B;
                    o_dec.imm = {{(XLEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25],
                                 i_inst[11:8], 1'b0};
                end
                LUI, AUIPC: begin
                    o_dec.typ = IMM_U;
                    o_dec.imm = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
                end
                JAL: begin
                    o_dec.typ = IMM_J;
                    o_dec.imm = {{(XLEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20],
                                 i_inst[30:21], 1'b0};
                end
                SYSTEM: begin
                    // CSR*I forms carry a 5-bit unsigned immediate in the rs1 field
                    if (w_f3[2] && (w_f3[1:0] != 2'b00)) begin
                        o_dec.typ = IMM_Z;
                        o_dec.imm = {{(XLEN-5){1'b0}}, i_inst[19:15]};
                    end
                end
                OP: ;
                OP32:    o_dec.illegal = !w_xl64;
                default: o_dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on the input side, one output register
// plus one skid entry so in_ready never depends combinationally on out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_type_e        out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
        logic            illegal;
    } dec_t;

    dec_t             w_dec;
    dec_t             r_out;
    dec_t             r_skid;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             w_in_fire;
    logic             w_out_load;

    imm_decode #(
        .XLEN  (XLEN),
        .dec_t (dec_t)
    ) u_dec (
        .i_inst (in_inst),
        .o_dec  (w_dec)
    );

    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_load = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_tag    <= '0;
            r_skid_tag   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
            // skid entry is older than anything on the input, so it goes first
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_tag    <= r_skid_tag;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out       <= w_dec;
                r_out_tag   <= in_tag;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_tag   <= in_tag;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out.imm;
    assign out_type    = r_out.typ;
    assign out_illegal = r_out.illegal;
    assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue-based reference with a rule-level immediate decoder.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_tag = '0;

    logic        rdy32, rdy64, vld32, vld64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_type(typ32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_type(typ64), .out_illegal(ill64), .out_tag(tag64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] tag;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   last_set = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic void ref_dec(input logic [31:0] i, input int xl,
                                    output logic [63:0] imm, output logic [2:0] typ,
                                    output logic ill);
        longint     v;
        logic [6:0] op;
        int         f3;
        v   = 0;
        typ = 3'd0;
        ill = 1'b0;
        op  = i[6:0];
        f3  = int'(i[14:12]);
        if (i[1:0] != 2'b11) ill = 1'b1;
        else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (op == 7'h1B && xl == 64)) begin
            typ = 3'd1;
            v   = sext(longint'(i[31:20]), 12);
            if ((f3 == 1 || f3 == 5) && i[25]) begin
                if (op == 7'h1B) ill = 1'b1;
                if (op == 7'h13 && xl == 32) ill = 1'b1;
            end
        end
        else if (op == 7'h1B) ill = 1'b1;
        else if (op == 7'h23) begin typ = 3'd2; v = sext(longint'({i[31:25], i[11:7]}), 12); end
        else if (op == 7'h63) begin
            typ = 3'd3;
            v   = sext(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
        end
        else if (op == 7'h37 || op == 7'h17) begin
            typ = 3'd4;
            v   = sext(longint'({i[31:12], 12'h000}), 32);
        end
        else if (op == 7'h6F) begin
            typ = 3'd5;
            v   = sext(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
        end
        else if (op == 7'h73) begin
            if (f3 >= 5) begin typ = 3'd6; v = longint'(i[19:15]); end
        end
        else if (op == 7'h33) ill = 1'b0;
        else if (op == 7'h3B) ill = (xl == 32);
        else ill = 1'b1;
        imm = (xl == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    task automatic check_outputs();
        ent_t        e;
        bit          have;
        logic [63:0] ei;
        logic [2:0]  et;
        logic        el;
        chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
        chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
        chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
        chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
        if (q.size() > 0) begin e = q[0]; have = 1'b1; end
        else begin e = last; have = last_set; end
        if (have) ref_dec(e.inst, 32, ei, et, el);
        else begin ei = '0; et = '0; el = 1'b0; e.tag = '0; end
        chk("imm32", 64'(imm32), ei);
        chk("type32", 64'(typ32), 64'(et));
        chk("illegal32", 64'(ill32), 64'(el));
        chk("tag32", 64'(tag32), 64'(e.tag));
        if (have) ref_dec(e.inst, 64, ei, et, el);
        chk("imm64", imm64, ei);
        chk("type64", 64'(typ64), 64'(et));
        chk("illegal64", 64'(ill64), 64'(el));
        chk("tag64", 64'(tag64), 64'(e.tag));
        if (q.size() > 0) begin last = q[0]; last_set = 1'b1; end
    endtask

    // Drive one cycle of inputs, advance the reference, then check after the edge.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                       input logic ordy, input logic fl);
        bit mdl_rdy;
        in_valid  = v;
        in_inst   = inst;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        mdl_rdy   = (q.size() < 2);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && mdl_rdy) q.push_back('{inst, tag});
        end
        @(negedge clk);
        check_outputs();
    endtask

    logic [31:0] t_inst [12] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7,
                                 32'h800002B7, 32'h3002D073, 32'h02009093, 32'h0000001B,
                                 32'h00000013, 32'h0000003B, 32'h00000000, 32'hFFDFF06F};
    logic [31:0] t_imm32 [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                  32'h80000000, 32'h5, 32'h20, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'hFFFFFFFC};
    logic [63:0] t_imm64 [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                  64'h12345000, 64'hFFFFFFFF80000000, 64'h5, 64'h20, 64'h0,
                                  64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  t_typ32 [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd5};
    logic [2:0]  t_typ64 [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd5};
    logic        t_ill32 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t_ill64 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B};

    initial begin
        logic [31:0] r;
        logic [31:0] inst;
        // reset values while rst is held
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_outputs();

        // format table, back-to-back with out_ready=1: each result one cycle later
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, t_inst[k], 32'h100 + k, 1'b1, 1'b0);
            chk("vec_imm32", 64'(imm32), 64'(t_imm32[k]));
            chk("vec_type32", 64'(typ32), 64'(t_typ32[k]));
            chk("vec_ill32", 64'(ill32), 64'(t_ill32[k]));
            chk("vec_imm64", imm64, t_imm64[k]);
            chk("vec_type64", 64'(typ64), 64'(t_typ64[k]));
            chk("vec_ill64", 64'(ill64), 64'(t_ill64[k]));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // back-pressure: A, B accepted, C waits, then drains in order
        cyc(1'b1, 32'hFFF00093, 32'hA, 1'b0, 1'b0);
        cyc(1'b1, 32'hFE20AE23, 32'hB, 1'b0, 1'b0);
        chk("bp_ready_drop", 64'(rdy32), 64'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'hFE000CE3, 32'hC, 1'b0, 1'b0);
        chk("bp_hold_tag", 64'(tag32), 64'hA);
        cyc(1'b1, 32'hFE000CE3, 32'hC, 1'b1, 1'b0);
        chk("bp_second_tag", 64'(tag32), 64'hB);
        cyc(1'b1, 32'hFE000CE3, 32'hC, 1'b1, 1'b0);
        chk("bp_third_tag", 64'(tag32), 64'hC);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_drained", 64'(vld32), 64'd0);

        // flush with output and skid full, input presented in the flush cycle
        cyc(1'b1, 32'h00000013, 32'hD1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000013, 32'hD2, 1'b0, 1'b0);
        cyc(1'b1, 32'h123452B7, 32'hD3, 1'b0, 1'b1);
        chk("flush_valid", 64'(vld32), 64'd0);
        chk("flush_ready", 64'(rdy32), 64'd1);
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        // flush with only the output full and in_ready high: input still dropped
        cyc(1'b1, 32'h00000013, 32'hE1, 1'b0, 1'b0);
        cyc(1'b1, 32'h800002B7, 32'hE2, 1'b1, 1'b1);
        chk("flush2_valid", 64'(vld64), 64'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r    = $urandom();
            inst = ($urandom_range(0, 9) == 0) ? r : {r[31:7], ops[$urandom_range(0, 11)]};
            cyc(($urandom_range(0, 3) != 0), inst, $urandom(),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        // asynchronous reset in the middle of a stall
        cyc(1'b1, 32'hFFF00093, 32'hF1, 1'b0, 1'b0);
        cyc(1'b1, 32'hFE20AE23, 32'hF2, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid32", 64'(vld32), 64'd0);
        chk("rst_valid64", 64'(vld64), 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_type32", 64'(typ32), 64'd0);
        chk("rst_ill32", 64'(ill32), 64'd0);
        chk("rst_tag32", 64'(tag32), 64'd0);
        chk("rst_tag64", 64'(tag64), 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd1);
        q.delete();
        last_set = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        for (int n = 0; n < 50; n++)
            cyc(($urandom_range(0, 1) != 0), {$urandom_range(0, 32'h1FFFFFF), 7'h13},
                $urandom(), ($urandom_range(0, 1) != 0), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
